// File: rtl/a51_keystream_ctrl_pkg.sv
// Shared constants, state type and phase helpers for the A5/1 keystream sequencer.
// Bit 0 of every register is the newest bit; the MSB is the output bit.
package a51_keystream_ctrl_pkg;

    localparam int unsigned LenA        = 19;
    localparam int unsigned LenB        = 22;
    localparam int unsigned LenC        = 23;
    localparam int unsigned KeyBits     = 64;
    localparam int unsigned FrameBits   = 22;
    localparam int unsigned FlushCycles = 23;
    localparam int unsigned MixCycles   = 100;
    localparam int unsigned KsBits      = 228;
    localparam int unsigned CntW        = 9;

    localparam int unsigned ClkBitA = 8;
    localparam int unsigned ClkBitB = 10;
    localparam int unsigned ClkBitC = 10;

    localparam int unsigned MsbA = LenA - 1;
    localparam int unsigned MsbB = LenB - 1;
    localparam int unsigned MsbC = LenC - 1;

    // Feedback tap masks: A {13,16,17,18}, B {20,21}, C {7,20,21,22}.
    localparam logic [LenA-1:0] TapsA = 19'h72000;
    localparam logic [LenB-1:0] TapsB = 22'h300000;
    localparam logic [LenC-1:0] TapsC = 23'h700080;

    typedef enum logic [2:0] {StIdle, StFlush, StKey, StFrame, StMix, StRun} state_e;

    function automatic logic [CntW-1:0] phase_last(input state_e st);
        case (st)
            StFlush: return CntW'(FlushCycles - 1);
            StKey:   return CntW'(KeyBits - 1);
            StFrame: return CntW'(FrameBits - 1);
            StMix:   return CntW'(MixCycles - 1);
            StRun:   return CntW'(KsBits - 1);
            default: return '0;
        endcase
    endfunction

    function automatic state_e phase_next(input state_e st);
        case (st)
            StFlush: return StKey;
            StKey:   return StFrame;
            StFrame: return StMix;
            StMix:   return StRun;
            default: return StIdle;
        endcase
    endfunction

endpackage

// File: rtl/a51_keystream_ctrl_if.sv
// Session handshake (start, key, frame) and keystream output of the A5/1 sequencer.
interface a51_keystream_ctrl_if;
    import a51_keystream_ctrl_pkg::*;

    logic                 start;
    logic [KeyBits-1:0]   key;
    logic [FrameBits-1:0] frame;
    logic                 busy;
    logic                 ks_valid;
    logic                 ks_bit;
    logic                 done;

    modport master (output start, key, frame, input busy, ks_valid, ks_bit, done);
    modport slave  (input start, key, frame, output busy, ks_valid, ks_bit, done);

endinterface

// File: rtl/a51_keystream_ctrl_majority.sv
// Majority vote over the three clocking bits; a register shifts when its bit agrees.
module a51_keystream_ctrl_majority (
    input  logic clk_bit_a,
    input  logic clk_bit_b,
    input  logic clk_bit_c,
    output logic en_a,
    output logic en_b,
    output logic en_c
);

    logic maj;

    assign maj  = (clk_bit_a & clk_bit_b) | (clk_bit_a & clk_bit_c) | (clk_bit_b & clk_bit_c);
    assign en_a = (clk_bit_a == maj);
    assign en_b = (clk_bit_b == maj);
    assign en_c = (clk_bit_c == maj);

endmodule

// File: rtl/a51_keystream_ctrl.sv
// A5/1 sequencer: flush, key load, frame load, majority mix and keystream phases,
// driving serial input and shift enable of three external LFSRs.
module a51_keystream_ctrl
    import a51_keystream_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    a51_keystream_ctrl_if.slave bus,
    input  logic [LenA-1:0]     ra_so,
    input  logic [LenB-1:0]     rb_so,
    input  logic [LenC-1:0]     rc_so,
    output logic                si_a,
    output logic                si_b,
    output logic                si_c,
    output logic                en_a,
    output logic                en_b,
    output logic                en_c
);

    state_e               state_q;
    logic [CntW-1:0]      cnt_q;
    logic [KeyBits-1:0]   key_q;
    logic [FrameBits-1:0] frame_q;
    logic                 busy_q;
    logic                 ks_valid_q;
    logic                 done_q;

    logic fa, fb, fc;
    logic load_bit;
    logic maj_en_a, maj_en_b, maj_en_c;

    assign fa = ^(ra_so & TapsA);
    assign fb = ^(rb_so & TapsB);
    assign fc = ^(rc_so & TapsC);

    a51_keystream_ctrl_majority u_majority (
        .clk_bit_a (ra_so[ClkBitA]),
        .clk_bit_b (rb_so[ClkBitB]),
        .clk_bit_c (rc_so[ClkBitC]),
        .en_a      (maj_en_a),
        .en_b      (maj_en_b),
        .en_c      (maj_en_c)
    );

    // The step counter doubles as the LSB-first bit index while loading.
    always_comb begin
        load_bit = 1'b0;
        if (state_q == StKey) begin
            load_bit = key_q[cnt_q[5:0]];
        end else if (state_q == StFrame) begin
            load_bit = frame_q[cnt_q[4:0]];
        end
    end

    always_comb begin
        si_a = 1'b0;
        si_b = 1'b0;
        si_c = 1'b0;
        en_a = 1'b0;
        en_b = 1'b0;
        en_c = 1'b0;
        case (state_q)
            StFlush: begin
                en_a = 1'b1;
                en_b = 1'b1;
                en_c = 1'b1;
            end
            StKey, StFrame: begin
                en_a = 1'b1;
                en_b = 1'b1;
                en_c = 1'b1;
                si_a = fa ^ load_bit;
                si_b = fb ^ load_bit;
                si_c = fc ^ load_bit;
            end
            StMix, StRun: begin
                en_a = maj_en_a;
                en_b = maj_en_b;
                en_c = maj_en_c;
                si_a = fa;
                si_b = fb;
                si_c = fc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            key_q      <= '0;
            frame_q    <= '0;
            busy_q     <= 1'b0;
            ks_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            ks_valid_q <= (state_q == StRun);
            done_q     <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        key_q   <= bus.key;
                        frame_q <= bus.frame;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= StFlush;
                    end
                end
                default: begin
                    if (cnt_q == phase_last(state_q)) begin
                        cnt_q   <= '0;
                        state_q <= phase_next(state_q);
                        if (state_q == StRun) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.ks_valid = ks_valid_q;
    assign bus.done     = done_q;
    assign bus.ks_bit   = ks_valid_q & (ra_so[MsbA] ^ rb_so[MsbB] ^ rc_so[MsbC]);

endmodule

// File: tb/tb_a51_keystream_ctrl.sv
// Bench for a51_keystream_ctrl: three LFSR loads, table-driven and random sessions
// checked against a behavioural A5/1 keystream model.
module tb_a51_keystream_ctrl;

    logic clk;
    logic rst;

    a51_keystream_ctrl_if bus ();

    logic si_a, si_b, si_c, en_a, en_b, en_c;
    logic [18:0] shift_register_a, ra_in, ovr_a;
    logic [21:0] shift_register_b, rb_in, ovr_b;
    logic [22:0] shift_register_c, rc_in, ovr_c;
    logic        ovr;

    int n_checks = 0;
    int n_errors = 0;

    a51_keystream_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .ra_so (ra_in),
        .rb_so (rb_in),
        .rc_so (rc_in),
        .si_a  (si_a),
        .si_b  (si_b),
        .si_c  (si_c),
        .en_a  (en_a),
        .en_b  (en_b),
        .en_c  (en_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Override lets the bench present arbitrary clocking bits to the controller.
    assign ra_in = ovr ? ovr_a : shift_register_a;
    assign rb_in = ovr ? ovr_b : shift_register_b;
    assign rc_in = ovr ? ovr_c : shift_register_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_register_a <= '0;
            shift_register_b <= '0;
            shift_register_c <= '0;
        end else begin
            if (en_a) shift_register_a <= {shift_register_a[17:0], si_a};
            if (en_b) shift_register_b <= {shift_register_b[20:0], si_b};
            if (en_c) shift_register_c <= {shift_register_c[21:0], si_c};
        end
    end

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference A5/1: load 64 key + 22 frame bits with all registers clocked,
    // then 100 discarded and 228 output majority-clocked steps.
    function automatic logic [227:0] ref_keystream(input logic [63:0] k, input logic [21:0] f);
        logic [18:0]  a;
        logic [21:0]  b;
        logic [22:0]  c;
        logic [227:0] ks;
        logic         fa, fb, fc, in_bit, maj;
        int           votes;
        a = '0;
        b = '0;
        c = '0;
        ks = '0;
        for (int i = 0; i < 86; i++) begin
            if (i < 64) in_bit = k[i];
            else        in_bit = f[i - 64];
            fa = a[13] ^ a[16] ^ a[17] ^ a[18];
            fb = b[20] ^ b[21];
            fc = c[7] ^ c[20] ^ c[21] ^ c[22];
            a = {a[17:0], fa ^ in_bit};
            b = {b[20:0], fb ^ in_bit};
            c = {c[21:0], fc ^ in_bit};
        end
        for (int s = 0; s < 328; s++) begin
            votes = int'(a[8]) + int'(b[10]) + int'(c[10]);
            maj = (votes >= 2);
            fa = a[13] ^ a[16] ^ a[17] ^ a[18];
            fb = b[20] ^ b[21];
            fc = c[7] ^ c[20] ^ c[21] ^ c[22];
            if (a[8] == maj)  a = {a[17:0], fa};
            if (b[10] == maj) b = {b[20:0], fb};
            if (c[10] == maj) c = {c[21:0], fc};
            if (s >= 100) ks[s - 100] = a[18] ^ b[21] ^ c[22];
        end
        return ks;
    endfunction

    // Per-session observations, sampled 1 time unit after each edge En.
    logic [227:0] s_ks;
    int           s_nvalid, s_first, s_last, s_done_n, s_done_cnt;
    logic         s_en_ok, s_busy_1, s_busy_437, s_valid_438, s_flush_nz;
    logic [63:0]  s_e24;

    task automatic run_session(input logic [63:0] k, input logic [21:0] f, input bit hold,
                               input bit skip, input bit disturb);
        if (!skip) begin
            @(negedge clk);
            bus.key   = k;
            bus.frame = f;
            bus.start = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.start   = hold;
        s_ks        = '0;
        s_nvalid    = 0;
        s_first     = -1;
        s_last      = -1;
        s_done_n    = -1;
        s_done_cnt  = 0;
        s_en_ok     = en_a & en_b & en_c;
        s_busy_1    = 1'b0;
        s_busy_437  = 1'b1;
        s_valid_438 = 1'b1;
        s_flush_nz  = 1'b1;
        s_e24       = '0;
        for (int n = 1; n <= 438; n++) begin
            @(posedge clk);
            #1;
            if (disturb && n == 50) begin
                bus.start = 1'b1;
                bus.key   = ~k;
            end
            if (disturb && n == 51) begin
                bus.start = 1'b0;
                bus.key   = k;
            end
            if (n <= 108) s_en_ok = s_en_ok & en_a & en_b & en_c;
            if (n == 1)   s_busy_1 = bus.busy;
            if (n == 23)  s_flush_nz = |{shift_register_a, shift_register_b, shift_register_c};
            if (n == 24)  s_e24 = {shift_register_a, shift_register_b, shift_register_c};
            if (bus.ks_valid) begin
                if (s_nvalid == 0) s_first = n;
                s_last = n;
                if (s_nvalid < 228) s_ks[s_nvalid] = bus.ks_bit;
                s_nvalid++;
            end
            if (bus.done) begin
                s_done_n = n;
                s_done_cnt++;
            end
            if (n == 437) s_busy_437 = bus.busy;
            if (n == 438) s_valid_438 = bus.ks_valid;
        end
    endtask

    task automatic check_session(input string tag, input logic [227:0] exp_ks,
                                 input logic [63:0] exp_e24);
        check({tag, "_keystream"}, s_ks, exp_ks);
        check({tag, "_valid_count"}, s_nvalid, 228);
        check({tag, "_first_valid_edge"}, s_first, 210);
        check({tag, "_last_valid_edge"}, s_last, 437);
        check({tag, "_done_edge"}, s_done_n, 437);
        check({tag, "_done_pulses"}, s_done_cnt, 1);
        check({tag, "_busy_e1"}, s_busy_1, 1'b1);
        check({tag, "_busy_e437"}, s_busy_437, 1'b0);
        check({tag, "_valid_e438"}, s_valid_438, 1'b0);
        check({tag, "_load_enables"}, s_en_ok, 1'b1);
        check({tag, "_flush_zero"}, s_flush_nz, 1'b0);
        check({tag, "_regs_e24"}, s_e24, exp_e24);
    endtask

    typedef struct {
        logic [63:0] key;
        logic [21:0] frame;
        bit          hold;
        bit          disturb;
        logic [63:0] exp_e24;
    } sess_t;

    typedef struct {
        bit a8, b10, c10;
        bit ea, eb, ec;
    } maj_t;

    localparam logic [63:0] E24One = {18'b0, 1'b1, 21'b0, 1'b1, 22'b0, 1'b1};
    localparam logic [63:0] KeyRef = 64'h1223456789ABCDEF;
    localparam logic [21:0] FrmRef = 22'h134;

    sess_t sess[5];
    maj_t  mtab[8];

    initial begin
        logic [63:0] rk;
        logic [21:0] rf;

        sess[0] = '{64'h0, 22'h0, 1'b0, 1'b0, 64'h0};
        sess[1] = '{64'h1, 22'h0, 1'b0, 1'b0, E24One};
        sess[2] = '{KeyRef, FrmRef, 1'b0, 1'b0, E24One};
        sess[3] = '{KeyRef, FrmRef, 1'b0, 1'b1, E24One};
        sess[4] = '{64'h0F0F_0000_1234_5678, 22'h2A5A5, 1'b1, 1'b0, 64'h0};

        mtab[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        mtab[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        mtab[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        mtab[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        mtab[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        mtab[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        mtab[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        mtab[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        rst       = 1'b0;
        ovr       = 1'b0;
        ovr_a     = '0;
        ovr_b     = '0;
        ovr_c     = '0;
        bus.start = 1'b0;
        bus.key   = '0;
        bus.frame = '0;

        repeat (2) @(negedge clk);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_ks_valid", bus.ks_valid, 1'b0);
        check("reset_done", bus.done, 1'b0);
        check("reset_si_en", {si_a, si_b, si_c, en_a, en_b, en_c}, 6'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", bus.busy, 1'b0);
        check("idle_en", {en_a, en_b, en_c}, 3'b0);

        for (int i = 0; i < 5; i++) begin
            run_session(sess[i].key, sess[i].frame, sess[i].hold, 1'b0, sess[i].disturb);
            check_session($sformatf("sess%0d", i), ref_keystream(sess[i].key, sess[i].frame),
                          sess[i].exp_e24);
            if (sess[i].hold) begin
                run_session(sess[i].key, sess[i].frame, 1'b0, 1'b1, 1'b0);
                check_session($sformatf("sess%0d_again", i),
                              ref_keystream(sess[i].key, sess[i].frame), sess[i].exp_e24);
            end
        end

        for (int i = 0; i < 4; i++) begin
            rk = {$urandom, $urandom};
            rf = 22'($urandom);
            run_session(rk, rf, 1'b0, 1'b0, ($urandom_range(0, 1) == 1));
            check_session($sformatf("rand%0d", i), ref_keystream(rk, rf),
                          rk[0] ? E24One : 64'h0);
        end

        // Majority clocking with forced clock bits during MIX.
        @(negedge clk);
        bus.key   = {$urandom, $urandom};
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (120) @(posedge clk);
        #1;
        ovr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ovr_a = 19'($urandom);
            ovr_b = 22'($urandom);
            ovr_c = 23'($urandom);
            ovr_a[8]  = mtab[i].a8;
            ovr_b[10] = mtab[i].b10;
            ovr_c[10] = mtab[i].c10;
            #1;
            check($sformatf("maj_en_%0d%0d%0d", mtab[i].a8, mtab[i].b10, mtab[i].c10),
                  {en_a, en_b, en_c}, {mtab[i].ea, mtab[i].eb, mtab[i].ec});
        end
        ovr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Reset in the middle of MIX, then a clean restart.
        @(negedge clk);
        bus.key   = KeyRef;
        bus.frame = FrmRef;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (150) @(posedge clk);
        #1;
        check("midmix_busy", bus.busy, 1'b1);
        rst = 1'b0;
        #1;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_ks_valid", {bus.ks_valid, bus.ks_bit}, 2'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_si_en", {si_a, si_b, si_c, en_a, en_b, en_c}, 6'b0);
        s_done_cnt = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (bus.done) s_done_cnt++;
        end
        check("rst_no_done", s_done_cnt, 0);
        rst = 1'b1;
        run_session(KeyRef, FrmRef, 1'b0, 1'b0, 1'b0);
        check_session("restart", ref_keystream(KeyRef, FrmRef), E24One);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
